prbs9_checker: RTL and testbench
================================

# prbs9_checker

PRBS9 receive-side checker sitting directly downstream of the `prbs9` generator, or of any link carrying its bit stream. It consumes one bit per enabled cycle and self-synchronises to the x^9 + x^5 + 1 sequence; no seed is needed. Once locked, it free-runs a local reference, compares every received bit, and accumulates bit and error counts for BER measurement. It drops lock when the error density in a sliding window exceeds a threshold.

## Interface
- `LOCK_MATCHES`, 32: consecutive matching bits required in SEARCH to declare lock (range 1..255).
- `WINDOW`, 64: length of the loss-of-lock observation window, in enabled bits (range 2..1023).
- `UNLOCK_ERRS`, 8: errors within one window that force loss of lock (range 1..WINDOW).
- `COUNT_W`, 32: width of the bit and error counters.
- `clock`  in  1  system clock; all state updates on the rising edge.
- `i_reset`  in  1  asynchronous, active-low reset; one clock; reset is asynchronous and active-low.
- `i_bit`  in  1  received bit, sampled only when `i_enable`=1.
- `i_enable`  in  1  qualifies `i_bit`; when 0, all state holds.
- `i_clear`  in  1  synchronous clear of `o_bit_count`, `o_err_count`, `o_lock_losses`; does not affect lock state.
- `o_locked`  out  1  1 in LOCKED state.
- `o_err`  out  1  one-cycle pulse: the bit just checked in LOCKED mismatched.
- `o_bit_count`  out  COUNT_W  enabled bits checked while LOCKED; saturates at all-ones.
- `o_err_count`  out  COUNT_W  mismatches while LOCKED; saturates at all-ones.
- `o_lock_losses`  out  8  LOCKED→SEARCH transitions; saturates at 255.

## Operation
- Recurrence: the generator output stream satisfies b[k] = b[k-9] XOR b[k-5]. A 9-bit history `h` holds the last 9 bits, with h[0] the newest. The prediction is p = h[8] XOR h[4].
- Reset: state=SEARCH, h=0, fill counter=0, match counter=0, window counters=0. All outputs are 0.
- SEARCH, per enabled bit:
  - The received bit shifts into `h`.
  - The first 9 enabled bits after reset or unlock only fill `h`; no comparison is made.
  - After the fill, compare `i_bit` against p computed from the pre-shift `h`. A match increments the match counter; a mismatch clears it.
  - If the pre-shift `h` is all zeros, the comparison counts as a mismatch. This prevents lock on a dead, all-zero line.
  - When the match counter reaches LOCK_MATCHES, go to LOCKED. The window counters are cleared.
- LOCKED, per enabled bit:
  - p is shifted into `h`, not `i_bit`. The reference free-runs, so a single line error produces exactly one counted error.
  - `o_bit_count` increments by 1.
  - If `i_bit` != p: `o_err_count` increments by 1, the window error counter increments by 1, and `o_err` pulses.
  - The window bit counter increments by 1. When it reaches WINDOW, both window counters reset to 0.
  - If the window error counter reaches UNLOCK_ERRS (counting the current bit), go to SEARCH:
    - clear the fill and match counters;
    - increment `o_lock_losses`;
    - the next 9 enabled bits refill `h`.
- Counters saturate at maximum and never wrap.
- Simultaneous events:
  - `i_clear` together with an increment: the clear wins, and the counter reads 0 next cycle.
  - `i_clear` together with loss of lock: `o_lock_losses` reads 0.
- `i_enable`=0: no shift, no compare, no count, and `o_err`=0. Gaps of any length are transparent.

## Timing
- All outputs are registered.
- `o_locked` rises on the clock edge that samples the LOCK_MATCHES-th consecutive matching enabled bit. The bit that triggers lock is not itself counted in `o_bit_count`.
- `o_err` and the counters update on the edge that samples the enabled bit (visible the following cycle). `o_err` is high for exactly one cycle per erroneous bit.
- `o_locked` falls on the edge that samples the UNLOCK_ERRS-th error in the window. That erroneous bit is still counted in both `o_bit_count` and `o_err_count`.
- Minimum lock time from reset with a clean stream and continuous enable: 9 + LOCK_MATCHES enabled bits (41 at defaults).
- Asserting `i_reset` low mid-operation clears all state and outputs immediately, independent of `clock`.

## Test plan
- Clean lock: `prbs9` (SEED 'h1AA) drives `i_bit`, with continuous enable. Required: `o_locked`=1 after the 41st bit; after 1000 more bits, `o_bit_count`=1000, `o_err_count`=0, `o_lock_losses`=0.
- Single error: invert one bit while locked. Required: one `o_err` pulse, `o_err_count`=1 (no error multiplication), `o_locked` stays 1.
- Unlock: inject 8 inverted bits within 64 bits. Required: `o_locked` falls on the 8th error; `o_lock_losses`=1; `o_err_count`=8; relock 41 clean bits later.
- Sub-threshold errors: 7 errors per 64-bit window, repeated for 10 windows. Required: lock is held; `o_err_count`=70.
- Dead line: constant 0 input for 500 bits. Required: `o_locked` never asserts. Enable gaps: random `i_enable` duty of 30% on a clean stream. Required: lock after 41 enabled bits; zero errors.
- Reset and clear: assert `i_reset` low mid-lock. Required: all outputs 0 asynchronously, followed by a relock. Then pulse `i_clear` in the same cycle as an error. Required: `o_err_count`=0 next cycle.

Source files
------------

// File: rtl/prbs9_checker.sv
// PRBS9 (x^9 + x^5 + 1) receive checker: self-synchronises on the incoming bit stream,
// then free-runs a local reference and accumulates bit/error counts for BER measurement.
module prbs9_checker #(
    parameter int LOCK_MATCHES = 32,
    parameter int WINDOW       = 64,
    parameter int UNLOCK_ERRS  = 8,
    parameter int COUNT_W      = 32
) (
    input  logic               clock,
    input  logic               i_reset,
    input  logic               i_bit,
    input  logic               i_enable,
    input  logic               i_clear,
    output logic               o_locked,
    output logic               o_err,
    output logic [COUNT_W-1:0] o_bit_count,
    output logic [COUNT_W-1:0] o_err_count,
    output logic [7:0]         o_lock_losses
);

    localparam int WIN_W = $clog2(WINDOW + 1);
    localparam logic [3:0]       FILL_LEN    = 4'd9;
    localparam logic [7:0]       MATCH_LAST  = 8'(LOCK_MATCHES - 1);
    localparam logic [WIN_W-1:0] WIN_LAST    = WIN_W'(WINDOW - 1);
    localparam logic [WIN_W-1:0] UNLOCK_LAST = WIN_W'(UNLOCK_ERRS - 1);

    typedef enum logic {
        ST_SEARCH = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [8:0]           r_hist;
    logic [3:0]           r_fill;
    logic [7:0]           r_match;
    logic [WIN_W-1:0]     r_win_bits;
    logic [WIN_W-1:0]     r_win_errs;
    logic                 r_err;
    logic [COUNT_W-1:0]   r_bit_count;
    logic [COUNT_W-1:0]   r_err_count;
    logic [7:0]           r_lock_losses;

    logic w_pred;
    logic w_hist_zero;
    logic w_fill_done;
    logic w_search_match;
    logic w_lock_hit;
    logic w_bit_err;
    logic w_win_end;
    logic w_unlock;
    logic w_search_step;
    logic w_locked_step;

    // h[8] is the bit 9 back, h[4] the bit 5 back: the recurrence predicts their XOR.
    always_comb begin
        w_pred         = r_hist[8] ^ r_hist[4];
        w_hist_zero    = (r_hist == 9'd0);
        w_fill_done    = (r_fill == FILL_LEN);
        w_search_match = w_fill_done && !w_hist_zero && (i_bit == w_pred);
        w_lock_hit     = w_search_match && (r_match == MATCH_LAST);
        w_bit_err      = (i_bit != w_pred);
        w_win_end      = (r_win_bits == WIN_LAST);
        w_unlock       = w_bit_err && (r_win_errs == UNLOCK_LAST);
        w_search_step  = i_enable && (r_state == ST_SEARCH);
        w_locked_step  = i_enable && (r_state == ST_LOCKED);
    end

    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= ST_SEARCH;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (i_enable) begin
            case (r_state)
                ST_SEARCH: if (w_lock_hit) w_state_next = ST_LOCKED;
                ST_LOCKED: if (w_unlock)   w_state_next = ST_SEARCH;
                default:                   w_state_next = ST_SEARCH;
            endcase
        end
    end

    always_comb begin
        o_locked      = (r_state == ST_LOCKED);
        o_err         = r_err;
        o_bit_count   = r_bit_count;
        o_err_count   = r_err_count;
        o_lock_losses = r_lock_losses;
    end

    // Once locked the history is fed from the prediction, not the line, so a
    // single flipped bit cannot corrupt the next nine predictions.
    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            r_hist  <= 9'd0;
            r_fill  <= 4'd0;
            r_match <= 8'd0;
        end else if (w_search_step) begin
            r_hist <= {r_hist[7:0], i_bit};
            if (!w_fill_done) begin
                r_fill <= r_fill + 4'd1;
            end
            if (w_search_match && !w_lock_hit) begin
                r_match <= r_match + 8'd1;
            end else begin
                r_match <= 8'd0;
            end
        end else if (w_locked_step) begin
            r_hist <= {r_hist[7:0], w_pred};
            if (w_unlock) begin
                r_fill  <= 4'd0;
                r_match <= 8'd0;
            end
        end
    end

    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            r_win_bits <= '0;
            r_win_errs <= '0;
        end else if (w_search_step) begin
            r_win_bits <= '0;
            r_win_errs <= '0;
        end else if (w_locked_step) begin
            if (w_win_end) begin
                r_win_bits <= '0;
                r_win_errs <= '0;
            end else begin
                r_win_bits <= r_win_bits + WIN_W'(1);
                if (w_bit_err) begin
                    r_win_errs <= r_win_errs + WIN_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_locked_step && w_bit_err;
        end
    end

    // Clear has priority over any increment landing on the same edge.
    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            r_bit_count   <= '0;
            r_err_count   <= '0;
            r_lock_losses <= 8'd0;
        end else if (i_clear) begin
            r_bit_count   <= '0;
            r_err_count   <= '0;
            r_lock_losses <= 8'd0;
        end else if (w_locked_step) begin
            if (r_bit_count != {COUNT_W{1'b1}}) begin
                r_bit_count <= r_bit_count + COUNT_W'(1);
            end
            if (w_bit_err && (r_err_count != {COUNT_W{1'b1}})) begin
                r_err_count <= r_err_count + COUNT_W'(1);
            end
            if (w_unlock && (r_lock_losses != 8'hFF)) begin
                r_lock_losses <= r_lock_losses + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_prbs9_checker.sv
// Bench for prbs9_checker: directed phase table, hand-written corner sequences and a
// randomized run, all compared cycle by cycle against a queue-based reference model.
module tb_prbs9_checker;

    localparam int LOCK_MATCHES = 32;
    localparam int WINDOW       = 64;
    localparam int UNLOCK_ERRS  = 8;
    localparam int COUNT_W      = 32;
    localparam longint CNT_MAX  = (64'd1 << COUNT_W) - 1;

    logic               clock = 1'b0;
    logic               i_reset = 1'b0;
    logic               i_bit = 1'b0;
    logic               i_enable = 1'b0;
    logic               i_clear = 1'b0;
    logic               o_locked;
    logic               o_err;
    logic [COUNT_W-1:0] o_bit_count;
    logic [COUNT_W-1:0] o_err_count;
    logic [7:0]         o_lock_losses;

    always #5 clock = ~clock;

    prbs9_checker #(
        .LOCK_MATCHES (LOCK_MATCHES),
        .WINDOW       (WINDOW),
        .UNLOCK_ERRS  (UNLOCK_ERRS),
        .COUNT_W      (COUNT_W)
    ) dut (
        .clock         (clock),
        .i_reset       (i_reset),
        .i_bit         (i_bit),
        .i_enable      (i_enable),
        .i_clear       (i_clear),
        .o_locked      (o_locked),
        .o_err         (o_err),
        .o_bit_count   (o_bit_count),
        .o_err_count   (o_err_count),
        .o_lock_losses (o_lock_losses)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: bit history as a queue (oldest first), windows by integer division.
    bit     m_locked;
    bit     m_err;
    bit     m_hist[$];
    int     m_seen;
    int     m_run;
    int     m_lock_idx;
    int     m_win_id;
    int     m_win_errs;
    longint m_bits;
    longint m_errs;
    longint m_losses;

    bit gen_hist[$];

    typedef struct {
        string  name;
        int     nbits;
        int     first;
        int     gap;
        int     nerr;
        int     period;
        bit     exp_locked;
        longint exp_bits;
        longint exp_errs;
        longint exp_losses;
    } phase_t;

    phase_t phases[8];

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic longint sat(input longint v, input longint maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    function automatic bit gen_next();
        bit b;
        b = gen_hist[0] ^ gen_hist[4];
        gen_hist.push_back(b);
        void'(gen_hist.pop_front());
        return b;
    endfunction

    task automatic model_reset();
        m_locked   = 1'b0;
        m_err      = 1'b0;
        m_hist.delete();
        m_seen     = 0;
        m_run      = 0;
        m_lock_idx = 0;
        m_win_id   = 0;
        m_win_errs = 0;
        m_bits     = 0;
        m_errs     = 0;
        m_losses   = 0;
    endtask

    task automatic model_step(input bit b, input bit en, input bit clr);
        bit p;
        bit zero;
        m_err = 1'b0;
        if (en) begin
            if (!m_locked) begin
                if (m_seen >= 9) begin
                    p = m_hist[0] ^ m_hist[4];
                    zero = 1'b1;
                    foreach (m_hist[i]) if (m_hist[i]) zero = 1'b0;
                    if (b == p && !zero) m_run++;
                    else m_run = 0;
                    if (m_run == LOCK_MATCHES) begin
                        m_locked   = 1'b1;
                        m_run      = 0;
                        m_lock_idx = 0;
                        m_win_id   = 0;
                        m_win_errs = 0;
                    end
                end
                m_seen++;
                m_hist.push_back(b);
            end else begin
                p = m_hist[0] ^ m_hist[4];
                if (m_lock_idx / WINDOW != m_win_id) begin
                    m_win_id   = m_lock_idx / WINDOW;
                    m_win_errs = 0;
                end
                m_bits++;
                if (b != p) begin
                    m_errs++;
                    m_err = 1'b1;
                    m_win_errs++;
                    if (m_win_errs == UNLOCK_ERRS) begin
                        m_locked = 1'b0;
                        m_seen   = 0;
                        m_run    = 0;
                        m_losses++;
                    end
                end
                m_lock_idx++;
                m_hist.push_back(p);
            end
            while (m_hist.size() > 9) void'(m_hist.pop_front());
        end
        if (clr) begin
            m_bits   = 0;
            m_errs   = 0;
            m_losses = 0;
        end
    endtask

    task automatic check_all();
        check("locked", longint'(o_locked), longint'(m_locked));
        check("err_pulse", longint'(o_err), longint'(m_err));
        check("bit_count", longint'(o_bit_count), sat(m_bits, CNT_MAX));
        check("err_count", longint'(o_err_count), sat(m_errs, CNT_MAX));
        check("lock_losses", longint'(o_lock_losses), sat(m_losses, 255));
    endtask

    // Called at a falling edge; returns at the next falling edge with outputs checked.
    task automatic step(input bit b, input bit en, input bit clr);
        i_bit    = b;
        i_enable = en;
        i_clear  = clr;
        @(posedge clock);
        model_step(b, en, clr);
        @(negedge clock);
        check_all();
    endtask

    task automatic do_reset(input string tag);
        @(negedge clock);
        #2 i_reset = 1'b0;
        #1;
        check({tag, "_rst_locked"}, longint'(o_locked), 0);
        check({tag, "_rst_err"}, longint'(o_err), 0);
        check({tag, "_rst_bits"}, longint'(o_bit_count), 0);
        check({tag, "_rst_errs"}, longint'(o_err_count), 0);
        check({tag, "_rst_losses"}, longint'(o_lock_losses), 0);
        model_reset();
        i_enable = 1'b0;
        i_clear  = 1'b0;
        @(negedge clock);
        i_reset = 1'b1;
        $display("reset %s: outputs cleared", tag);
    endtask

    task automatic set_phase(input int i, input string n, input int nb, input int f, input int g,
                             input int ne, input int per, input bit el, input longint eb,
                             input longint ee, input longint elo);
        phases[i].name       = n;
        phases[i].nbits      = nb;
        phases[i].first      = f;
        phases[i].gap        = g;
        phases[i].nerr       = ne;
        phases[i].period     = per;
        phases[i].exp_locked = el;
        phases[i].exp_bits   = eb;
        phases[i].exp_errs   = ee;
        phases[i].exp_losses = elo;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [8:0] seed;
        bit b;
        bit en;
        bit saw;
        int en_cnt;
        int cyc;
        int rate;

        // Absolute counter values, accumulated phase by phase from lock.
        set_phase(0, "prelock",    40,   0, 1, 0, 64, 1'b0, 0,    0,  0);
        set_phase(1, "lock",       1,    0, 1, 0, 64, 1'b1, 0,    0,  0);
        set_phase(2, "clean1000",  1000, 0, 1, 0, 64, 1'b1, 1000, 0,  0);
        set_phase(3, "single_err", 64,   10, 1, 1, 64, 1'b1, 1064, 1,  0);
        set_phase(4, "sub_thresh", 640,  0, 1, 7, 64, 1'b1, 1704, 71, 0);
        set_phase(5, "unlock",     16,   0, 2, 8, 64, 1'b0, 1719, 79, 1);
        set_phase(6, "relock_pre", 39,   0, 1, 0, 64, 1'b0, 1719, 79, 1);
        set_phase(7, "relock",     1,    0, 1, 0, 64, 1'b1, 1719, 79, 1);

        seed = 9'h1AA;
        for (int i = 0; i < 9; i++) gen_hist.push_back(seed[i]);

        do_reset("initial");

        for (int pi = 0; pi < 8; pi++) begin
            for (int o = 0; o < phases[pi].nbits; o++) begin
                int  r;
                bit  inj;
                r   = o % phases[pi].period;
                inj = (phases[pi].nerr > 0) && (r >= phases[pi].first) &&
                      (((r - phases[pi].first) % phases[pi].gap) == 0) &&
                      (((r - phases[pi].first) / phases[pi].gap) < phases[pi].nerr);
                b = gen_next();
                step(b ^ inj, 1'b1, 1'b0);
            end
            check({phases[pi].name, "_locked"}, longint'(o_locked), longint'(phases[pi].exp_locked));
            check({phases[pi].name, "_bits"}, longint'(o_bit_count), phases[pi].exp_bits);
            check({phases[pi].name, "_errs"}, longint'(o_err_count), phases[pi].exp_errs);
            check({phases[pi].name, "_losses"}, longint'(o_lock_losses), phases[pi].exp_losses);
            $display("phase %s: locked=%0d bits=%0d errs=%0d losses=%0d", phases[pi].name,
                     o_locked, o_bit_count, o_err_count, o_lock_losses);
        end

        // Asynchronous reset in the middle of lock, then relock with a 30% enable duty.
        for (int i = 0; i < 20; i++) begin
            b = gen_next();
            step(b, 1'b1, 1'b0);
        end
        do_reset("midlock");
        en_cnt = 0;
        cyc    = 0;
        while (en_cnt < 41 && cyc < 2000) begin
            en = ($urandom_range(0, 99) < 30);
            if (en) begin
                b = gen_next();
                en_cnt++;
            end else begin
                b = 1'($urandom_range(0, 1));
            end
            step(b, en, 1'b0);
            if (en && en_cnt == 40) check("gap_prelock", longint'(o_locked), 0);
            cyc++;
        end
        check("gap_budget", longint'(en_cnt), 41);
        check("gap_locked", longint'(o_locked), 1);
        check("gap_errs", longint'(o_err_count), 0);
        check("gap_bits", longint'(o_bit_count), 0);
        $display("sequence gaps: locked after %0d cycles", cyc);

        // Clear in the same cycle as an error: the error pulses but the counters read 0.
        b = gen_next();
        step(~b, 1'b1, 1'b1);
        check("clr_err_count", longint'(o_err_count), 0);
        check("clr_bit_count", longint'(o_bit_count), 0);
        check("clr_err_pulse", longint'(o_err), 1);
        check("clr_locked", longint'(o_locked), 1);
        $display("sequence clear_with_error: errs=%0d err=%0d", o_err_count, o_err);

        // Seven more errors in the same window: the last one unlocks while clear is held.
        for (int i = 1; i <= 7; i++) begin
            b = gen_next();
            step(~b, 1'b1, (i == 7));
            if (i == 6) begin
                check("pre_unlock_errs", longint'(o_err_count), 6);
                check("pre_unlock_bits", longint'(o_bit_count), 6);
                check("pre_unlock_locked", longint'(o_locked), 1);
            end
        end
        check("clr_unlock_locked", longint'(o_locked), 0);
        check("clr_unlock_losses", longint'(o_lock_losses), 0);
        check("clr_unlock_errs", longint'(o_err_count), 0);
        $display("sequence clear_with_unlock: locked=%0d losses=%0d", o_locked, o_lock_losses);

        // Dead line: all-zero input must never lock.
        do_reset("dead");
        saw = 1'b0;
        for (int i = 0; i < 500; i++) begin
            step(1'b0, 1'b1, 1'b0);
            saw |= o_locked;
        end
        check("dead_never_locked", longint'(saw), 0);
        $display("sequence dead_line: saw_lock=%0d", saw);

        // Repeated lock/unlock cycles drive the loss counter into saturation.
        do_reset("saturate");
        for (int it = 0; it < 257; it++) begin
            for (int i = 0; i < 41; i++) begin
                b = gen_next();
                step(b, 1'b1, 1'b0);
            end
            for (int i = 0; i < 8; i++) begin
                b = gen_next();
                step(~b, 1'b1, 1'b0);
            end
            if (it == 254) check("losses_at_255", longint'(o_lock_losses), 255);
        end
        check("losses_saturated", longint'(o_lock_losses), 255);
        check("sat_locked", longint'(o_locked), 0);
        $display("sequence saturate: losses=%0d", o_lock_losses);

        // Random enable, clear and error density from a random point in the sequence.
        do_reset("random");
        for (int i = 0; i < int'($urandom_range(0, 510)); i++) void'(gen_next());
        for (int blk = 0; blk < 8; blk++) begin
            rate = (blk % 2 == 1) ? 6 : 120;
            for (int i = 0; i < 500; i++) begin
                bit clr;
                en  = ($urandom_range(0, 9) < 7);
                clr = ($urandom_range(0, 299) == 0);
                if (en) b = gen_next() ^ ($urandom_range(0, rate - 1) == 0);
                else    b = 1'($urandom_range(0, 1));
                step(b, en, clr);
            end
            $display("random block %0d: locked=%0d bits=%0d errs=%0d losses=%0d", blk,
                     o_locked, o_bit_count, o_err_count, o_lock_losses);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
